// File: rtl/skewed_fifo_bank_if.sv
// Producer/consumer bundle for skewed_fifo_bank: round-robin write port,
// row read port with per-lane skewed outputs, and occupancy/error status.
interface skewed_fifo_bank_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 5,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int SW    = (LANES > 1) ? $clog2(LANES) : 1
);
  logic                   flush;
  logic                   wr_valid;
  logic [WIDTH-1:0]       wr_data;
  logic                   wr_ready;
  logic                   wr_lane_clr;
  logic [SW-1:0]          wr_sel;
  logic                   rd_en;
  logic [LANES*WIDTH-1:0] rd_data;
  logic [LANES-1:0]       rd_valid;
  logic [LANES-1:0]       lane_empty;
  logic [LANES-1:0]       lane_full;
  logic [CW-1:0]          rows_avail;
  logic                   err_underflow;

  modport master (
    output flush, wr_valid, wr_data, wr_lane_clr, rd_en,
    input  wr_ready, wr_sel, rd_data, rd_valid, lane_empty, lane_full,
           rows_avail, err_underflow
  );

  modport slave (
    input  flush, wr_valid, wr_data, wr_lane_clr, rd_en,
    output wr_ready, wr_sel, rd_data, rd_valid, lane_empty, lane_full,
           rows_avail, err_underflow
  );
endinterface

// File: rtl/skewed_fifo_bank.sv
// Bank of LANES FIFOs fed round-robin and drained one row at a time, with a
// per-lane delay line so lane i reaches a systolic array edge i cycles later.
module skewed_fifo_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int DLY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);
  localparam int AW  = $clog2(DEPTH);
  localparam int VW  = DLY + 1;
  localparam int DPW = (DLY + 1) * WIDTH;

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [CW-1:0]            cnt;
  logic [DLY:0]             vld_pipe;
  logic [DLY:0][WIDTH-1:0]  dat_pipe;
  logic [WIDTH-1:0]         rd_word;
  logic                     clr;

  assign clr = rst || flush;
  // Idle slots carry zero so padding never exposes stale RAM contents.
  assign rd_word = pop ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt      <= cnt + CW'(push) - CW'(pop);
      // Stage 0 is the RAM read register; later stages are the skew delay.
      vld_pipe <= VW'({vld_pipe, pop});
      dat_pipe <= DPW'({dat_pipe, rd_word});
    end
  end

  assign count  = cnt;
  assign rvalid = vld_pipe[DLY];
  assign rdata  = dat_pipe[DLY];
endmodule

module skewed_fifo_bank #(
  parameter int WIDTH = 32,
  parameter int LANES = 5,
  parameter int DEPTH = 64,
  parameter int SKEW  = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  skewed_fifo_bank_if.slave bus
);
  localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [SW-1:0]                sel;
  logic [LANES-1:0][CW-1:0]     cnt;
  logic [LANES-1:0][WIDTH-1:0]  lane_data;
  logic [LANES-1:0]             lane_vld, full, empty, push;
  logic [CW-1:0]                min_cnt;
  logic                         wr_acc, rd_ok, rd_bad, err;

  always_comb begin
    min_cnt = cnt[0];
    for (int i = 0; i < LANES; i++) begin
      full[i]  = (cnt[i] == CW'(DEPTH));
      empty[i] = (cnt[i] == '0);
      if (cnt[i] < min_cnt) min_cnt = cnt[i];
    end
  end

  assign bus.wr_ready = !full[sel];
  assign wr_acc       = bus.wr_valid && !full[sel];
  assign rd_ok        = bus.rd_en && (min_cnt != '0);
  assign rd_bad       = bus.rd_en && (min_cnt == '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign push[g] = wr_acc && (sel == SW'(g));
    skewed_fifo_lane #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW),
      .DLY(1 + ((SKEW != 0) ? g : 0))
    ) u_lane (
      .clk(clk), .rst(rst), .flush(bus.flush),
      .push(push[g]), .pop(rd_ok), .wdata(bus.wr_data),
      .count(cnt[g]), .rdata(lane_data[g]), .rvalid(lane_vld[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush)  sel <= '0;
    else if (bus.wr_lane_clr) sel <= '0;
    else if (wr_acc)       sel <= (sel == SW'(LANES - 1)) ? '0 : sel + SW'(1);
  end

  // Sticky until reset; a read discarded by flush is not an underflow.
  always_ff @(posedge clk) begin
    if (rst)                       err <= 1'b0;
    else if (rd_bad && !bus.flush) err <= 1'b1;
  end

  assign bus.wr_sel        = sel;
  assign bus.rd_data       = lane_data;
  assign bus.rd_valid      = lane_vld;
  assign bus.lane_empty    = empty;
  assign bus.lane_full     = full;
  assign bus.rows_avail    = min_cnt;
  assign bus.err_underflow = err;
endmodule
